// File: rtl/piece_queue_pkg.sv
// Shared definitions for the piece queue.
// Holds the piece index type and encoding, the empty marker, the full-bag
// mask value and the queue FSM state type.
package piece_queue_pkg;

  typedef enum logic [2:0] {
    PIECE_I     = 3'd0,
    PIECE_J     = 3'd1,
    PIECE_L     = 3'd2,
    PIECE_O     = 3'd3,
    PIECE_S     = 3'd4,
    PIECE_T     = 3'd5,
    PIECE_Z     = 3'd6,
    PIECE_EMPTY = 3'd7
  } piece_e;

  typedef logic [2:0] piece_t;

  localparam piece_t     EMPTY    = piece_t'(PIECE_EMPTY);
  localparam logic [6:0] BAG_FULL = 7'h7F;

  typedef enum logic {
    S_FILL,
    S_READY
  } state_e;

endpackage

// File: rtl/piece_queue_bag_randomizer.sv
// 7-bag piece randomizer.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   draw        consume the presented piece; advances LFSR and bag mask
//   new_game    reload the bag to full (LFSR keeps its value)
//   piece       piece that the next draw will take (combinational)
module bag_randomizer
  import piece_queue_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   draw,
  input  logic   new_game,
  output piece_t piece
);

  logic [15:0] lfsr_q, lfsr_d;
  logic [6:0]  mask_q, mask_d;
  logic [6:0]  cleared;
  logic [2:0]  r;
  logic [2:0]  idx3;
  int unsigned idx;
  logic        found;

  // First still-available piece at or above r, wrapping 6 -> 0.
  always_comb begin
    r     = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    piece = '0;
    found = 1'b0;
    idx   = 0;
    idx3  = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      idx = {29'd0, r} + k;
      if (idx >= 32'd7) idx = idx - 32'd7;
      idx3 = idx[2:0];
      if (!found && mask_q[idx3]) begin
        found = 1'b1;
        piece = idx3;
      end
    end
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    mask_d  = mask_q;
    cleared = mask_q & ~(7'd1 << piece);
    if (draw) begin
      // Taps 16,14,13,11 in right-shifting Fibonacci form.
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      mask_d = (cleared == '0) ? BAG_FULL : cleared;
    end
    if (new_game) mask_d = BAG_FULL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      mask_q <= BAG_FULL;
    end else begin
      lfsr_q <= lfsr_d;
      mask_q <= mask_d;
    end
  end

endmodule

// File: rtl/piece_queue.sv
// Piece queue: current piece, preview window and hold slot fed by a 7-bag
// randomizer.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   new_game           synchronous restart (highest priority)
//   req_next           consume current piece, spawn next
//   req_hold           hold / swap current piece (once per piece)
//   ready              queue primed, requests accepted
//   curr_idx           current piece
//   preview            upcoming pieces, element 0 soonest
//   hold_idx           held piece, 7 when empty
//   hold_used          hold already used for this piece
//   spawn              one-cycle pulse when curr_idx changed by a request
module piece_queue
  import piece_queue_pkg::*;
#(
  parameter int unsigned PREVIEW_DEPTH = 3,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter bit          HOLD_EN       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          new_game,
  input  logic                          req_next,
  input  logic                          req_hold,
  output logic                          ready,
  output logic [2:0]                    curr_idx,
  output logic [PREVIEW_DEPTH-1:0][2:0] preview,
  output logic [2:0]                    hold_idx,
  output logic                          hold_used,
  output logic                          spawn
);

  localparam int unsigned IDX_W = (PREVIEW_DEPTH > 1) ? $clog2(PREVIEW_DEPTH) : 1;

  state_e                        state_q, state_d;
  logic [2:0]                    cnt_q, cnt_d;
  piece_t                        curr_q, curr_d;
  logic [PREVIEW_DEPTH-1:0][2:0] prev_q, prev_d;
  logic [PREVIEW_DEPTH:0][2:0]   shifted;
  piece_t                        hold_q, hold_d;
  logic                          used_q, used_d;
  logic                          spawn_q, spawn_d;
  logic                          draw;
  logic                          shift;
  piece_t                        piece;

  bag_randomizer #(
    .LFSR_SEED(LFSR_SEED)
  ) u_bag (
    .clk     (clk),
    .rst_n   (rst_n),
    .draw    (draw),
    .new_game(new_game),
    .piece   (piece)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    curr_d  = curr_q;
    prev_d  = prev_q;
    hold_d  = hold_q;
    used_d  = used_q;
    spawn_d = 1'b0;
    draw    = 1'b0;
    shift   = 1'b0;
    shifted = {piece, prev_q};

    if (new_game) begin
      state_d = S_FILL;
      cnt_d   = '0;
      curr_d  = EMPTY;
      prev_d  = '1;
      hold_d  = EMPTY;
      used_d  = 1'b0;
    end else if (state_q == S_FILL) begin
      draw = 1'b1;
      if (cnt_q == '0) curr_d = piece;
      for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
        if (cnt_q == 3'(i + 1)) prev_d[IDX_W'(i)] = piece;
      end
      if (cnt_q == 3'(PREVIEW_DEPTH)) state_d = S_READY;
      else cnt_d = cnt_q + 3'd1;
    end else if (req_next) begin
      shift   = 1'b1;
      used_d  = 1'b0;
      spawn_d = 1'b1;
    end else if (req_hold && HOLD_EN && !used_q) begin
      used_d  = 1'b1;
      spawn_d = 1'b1;
      hold_d  = curr_q;
      if (hold_q == EMPTY) shift = 1'b1;
      else curr_d = hold_q;
    end

    if (shift) begin
      draw   = 1'b1;
      curr_d = prev_q[0];
      prev_d = shifted[PREVIEW_DEPTH:1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      curr_q  <= EMPTY;
      prev_q  <= '1;
      hold_q  <= EMPTY;
      used_q  <= 1'b0;
      spawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      curr_q  <= curr_d;
      prev_q  <= prev_d;
      hold_q  <= hold_d;
      used_q  <= used_d;
      spawn_q <= spawn_d;
    end
  end

  assign ready     = (state_q == S_READY);
  assign curr_idx  = curr_q;
  assign preview   = prev_q;
  assign hold_idx  = hold_q;
  assign hold_used = used_q;
  assign spawn     = spawn_q;

endmodule
